muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Constant: WORD, 32, datapath width, taken from definitions.vh.
REQ-002 Constant: CYCLE, as defined in definitions.vh, clock period used by benches.
REQ-003 The block SHALL use one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 Port: clk  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  synchronous active-high reset.
REQ-006 Port: start  in  1  request; sampled only when idle.
REQ-007 Port: op  in  2  00 MULLO, 01 MULHI, 10 DIVU (quotient), 11 REMU (remainder).
REQ-008 Port: A  in  WORD  operand A, driven by the regfile A read port.
REQ-009 Port: B  in  WORD  operand B, driven by the regfile B read port.
REQ-010 Port: dest  in  5  destination register index.
REQ-011 Port: busy  out  1  operation in progress; new starts ignored.
REQ-012 Port: write  out  1  one-cycle write strobe to regfile write.
REQ-013 Port: address_dest  out  5  to regfile address_dest.
REQ-014 Port: write_data  out  WORD  to regfile write_data.

Function
REQ-015 The block SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-016 IDLE: start=1 at a rising edge SHALL latch A, B, op, dest and enter RUN; start=0 stays IDLE.
REQ-017 RUN SHALL last exactly WORD cycles, one iteration per cycle, tracked by a counter 0..WORD-1, then enter DONE.
REQ-018 DONE SHALL last one cycle, then return to IDLE; the next start is accepted at the edge ending DONE+1 (IDLE).
REQ-019 Latency: for start sampled at edge k, write SHALL be high during the cycle after edge k+WORD+1 (i.e. from edge k+WORD+1 to k+WORD+2).
REQ-020 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-021 write SHALL be 1 only in DONE and only if latched dest != 0; otherwise 0.
REQ-022 address_dest SHALL equal latched dest and write_data the selected result while in DONE; both hold last values otherwise.
REQ-023 Multiply: unsigned shift-add into a 2*WORD product; MULLO returns bits WORD-1:0, MULHI bits 2*WORD-1:WORD.
REQ-024 Divide: unsigned restoring division, WORD-bit quotient and remainder, WORD+1-bit partial remainder.
REQ-025 B=0 on DIVU SHALL give all-ones; on REMU SHALL give latched A; latency unchanged.
REQ-026 start while busy=1 (including DONE cycle) SHALL be ignored with no effect on latched operands.
REQ-027 Operand changes on A/B/dest after the start edge SHALL not affect the result.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE, counter 0, busy 0, write 0, address_dest 0, write_data 0.
REQ-029 reset SHALL take priority over start at the same edge.
REQ-030 reset during RUN or DONE SHALL abort with no write pulse in any later cycle.

Structure
REQ-031 op encodings (MULLO, MULHI, DIVU, REMU) SHALL be defined as macros in definitions.vh alongside WORD and CYCLE.
REQ-032 The block SHALL be a single module; no sub-module, multiply and divide share the counter and FSM.
REQ-033 The block SHALL drive regfile write, address_dest and write_data directly, with no other writer in the same cycle.

Verification
REQ-034 MULLO A=7, B=6, dest=5 -> write=1 exactly one cycle, write_data=42, address_dest=5, WORD+1 edges after start.
REQ-035 MULHI A=0xFFFFFFFF, B=0xFFFFFFFF -> write_data=0xFFFFFFFE; MULLO same operands -> 0x00000001.
REQ-036 DIVU A=100, B=7 -> 14; REMU same -> 2; DIVU A=25, B=0 -> 0xFFFFFFFF; REMU -> 25.
REQ-037 Start MULLO 3*4, dest=2; pulse start with 9*9 at cycle 5 -> single write of 12 to r2, no second write.
REQ-038 Start DIVU, assert reset at RUN cycle 10 -> busy=0 and write=0 next cycle, no write through next 40 cycles.
REQ-039 MULLO 5*5 with dest=0 -> busy timing as normal, write stays 0 throughout.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared constants and helpers for the iterative multiply/divide unit.
//   WORD   - datapath width
//   CYCLE  - clock period used by benches
//   MULLO/MULHI/DIVU/REMU - op encodings
//   IDLE/RUN/DONE         - FSM state encodings
//   select_result()       - final result mux applied in DONE
package muldiv_unit_pkg;

  localparam int unsigned WORD  = 32;
  localparam int unsigned CYCLE = 10;
  localparam int unsigned CNT_W = $clog2(WORD);

  localparam logic [1:0] MULLO = 2'b00;
  localparam logic [1:0] MULHI = 2'b01;
  localparam logic [1:0] DIVU  = 2'b10;
  localparam logic [1:0] REMU  = 2'b11;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // acc holds the product high word (multiply) or the remainder (divide);
  // lo holds the product low word (multiply) or the quotient (divide).
  function automatic logic [WORD-1:0] select_result(
    input logic [1:0]      op,
    input logic [WORD-1:0] acc,
    input logic [WORD-1:0] lo,
    input logic [WORD-1:0] a,
    input logic [WORD-1:0] b
  );
    logic [WORD-1:0] res;
    unique case (op)
      MULLO:   res = lo;
      MULHI:   res = acc;
      // Division by zero: all-ones quotient, dividend as remainder.
      DIVU:    res = (b == '0) ? '1 : lo;
      default: res = (b == '0) ? a : acc;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit writing its result to the register file.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle, WORD cycles
// per operation, sharing a single counter, FSM and datapath registers.
//   clk          - rising-edge clock
//   reset        - synchronous active-high reset
//   start        - request, sampled only when idle
//   op           - MULLO / MULHI / DIVU / REMU
//   A, B         - operands (latched on the accepted start edge)
//   dest         - destination register index (latched with operands)
//   busy         - high while an operation is in RUN or DONE
//   write        - one-cycle regfile write strobe, suppressed for dest 0
//   address_dest - regfile write address
//   write_data   - regfile write data
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [WORD-1:0] A,
  input  logic [WORD-1:0] B,
  input  logic [4:0]      dest,
  output logic            busy,
  output logic            write,
  output logic [4:0]      address_dest,
  output logic [WORD-1:0] write_data
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WORD - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD-1:0]  acc_q, acc_d;
  logic [WORD-1:0]  lo_q, lo_d;

  logic [1:0]       op_q;
  logic [WORD-1:0]  a_q, b_q;
  logic [4:0]       dest_q;

  logic             busy_q, write_q;
  logic [4:0]       addr_q;
  logic [WORD-1:0]  data_q;

  logic             accept;
  logic             is_mul;
  logic [WORD:0]    mul_sum;
  logic [WORD:0]    div_shift;
  logic [WORD:0]    div_trial;

  assign accept = (state_q == IDLE) && start;
  assign is_mul = ~op_q[1];

  // Multiply step: add B into the high half when the multiplier LSB is set, then shift the
  // {carry, acc, lo} product right by one. lo starts as A and is consumed from the bottom.
  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);

  // Restoring divide step on a WORD+1-bit partial remainder. The borrow bit (MSB of the
  // trial) is only meaningful for B != 0; B == 0 is resolved in select_result().
  assign div_shift = {acc_q, lo_q[WORD-1]};
  assign div_trial = div_shift - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
          lo_d    = A;
        end
      end
      RUN: begin
        if (is_mul) begin
          acc_d = mul_sum[WORD:1];
          lo_d  = {mul_sum[0], lo_q[WORD-1:1]};
        end else if (div_trial[WORD]) begin
          acc_d = div_shift[WORD-1:0];
          lo_d  = {lo_q[WORD-2:0], 1'b0};
        end else begin
          acc_d = div_trial[WORD-1:0];
          lo_d  = {lo_q[WORD-2:0], 1'b1};
        end
        if (cnt_q == CntLast) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
    end
  end

  // Operands are captured only on an accepted start, so later input changes and starts
  // arriving while busy leave them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= MULLO;
      a_q    <= '0;
      b_q    <= '0;
      dest_q <= '0;
    end else if (accept) begin
      op_q   <= op;
      a_q    <= A;
      b_q    <= B;
      dest_q <= dest;
    end
  end

  // Registered outputs: the result captured during DONE is presented in the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (state_q == DONE) begin
        write_q <= (dest_q != '0);
        addr_q  <= dest_q;
        data_q  <= select_result(op_q, acc_q, lo_q, a_q, b_q);
      end else begin
        write_q <= 1'b0;
      end
    end
  end

  assign busy         = busy_q;
  assign write        = write_q;
  assign address_dest = addr_q;
  assign write_data   = data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic            clk;
  logic            reset;
  logic            start;
  logic [1:0]      op;
  logic [WORD-1:0] A;
  logic [WORD-1:0] B;
  logic [4:0]      dest;
  logic            busy;
  logic            write;
  logic [4:0]      address_dest;
  logic [WORD-1:0] write_data;

  int vectors;
  int miscompares;

  muldiv_unit dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op           (op),
    .A            (A),
    .B            (B),
    .dest         (dest),
    .busy         (busy),
    .write        (write),
    .address_dest (address_dest),
    .write_data   (write_data)
  );

  initial clk = 1'b0;
  always #(CYCLE / 2) clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and observe it. Offsets count edges after the start edge.
  task automatic do_op(input logic [1:0] o, input logic [WORD-1:0] a, input logic [WORD-1:0] b,
                       input logic [4:0] d, output int first_w, output int n_w,
                       output logic [WORD-1:0] data, output logic [4:0] addr,
                       output int busy_hi);
    op = o; A = a; B = b; dest = d; start = 1'b1;
    tick();
    start = 1'b0;
    A = $urandom; B = $urandom; dest = 5'($urandom);
    first_w = -1; n_w = 0; busy_hi = 0; data = '0; addr = '0;
    for (int i = 0; i <= int'(WORD) + 5; i++) begin
      if (i > 0) tick();
      if (busy) busy_hi++;
      if (write) begin
        n_w++;
        if (first_w < 0) first_w = i;
      end
      if (i == int'(WORD) + 1) begin
        data = write_data;
        addr = address_dest;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = MULLO; A = '0; B = '0; dest = '0;
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
    vectors++;
    if (write !== 1'b0) begin
      miscompares++; $display("FAIL reset_write: got %b expected 0", write);
    end
    vectors++;
    if (address_dest !== 5'd0) begin
      miscompares++; $display("FAIL reset_addr: got %0d expected 0", address_dest);
    end
    vectors++;
    if (write_data !== 32'd0) begin
      miscompares++; $display("FAIL reset_data: got %0h expected 0", write_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mullo();
    int fw, nw, bh;
    logic [WORD-1:0] d;
    logic [4:0] ad;
    do_op(MULLO, 32'd7, 32'd6, 5'd5, fw, nw, d, ad, bh);
    vectors++;
    if (fw !== int'(WORD) + 1) begin
      miscompares++; $display("FAIL mullo_latency: got %0d expected %0d", fw, WORD + 1);
    end
    vectors++;
    if (nw !== 1) begin
      miscompares++; $display("FAIL mullo_write_count: got %0d expected 1", nw);
    end
    vectors++;
    if (d !== 32'd42) begin
      miscompares++; $display("FAIL mullo_data: got %0d expected 42", d);
    end
    vectors++;
    if (ad !== 5'd5) begin
      miscompares++; $display("FAIL mullo_addr: got %0d expected 5", ad);
    end
    vectors++;
    if (bh !== int'(WORD) + 1) begin
      miscompares++; $display("FAIL mullo_busy_cycles: got %0d expected %0d", bh, WORD + 1);
    end
  endtask

  task automatic test_mul_wide();
    int fw, nw, bh;
    logic [WORD-1:0] d;
    logic [4:0] ad;
    do_op(MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'hFFFF_FFFE) begin
      miscompares++; $display("FAIL mulhi_ones: got %0h expected fffffffe", d);
    end
    do_op(MULLO, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'h0000_0001) begin
      miscompares++; $display("FAIL mullo_ones: got %0h expected 1", d);
    end
    // 0x80000000 * 4 = 2^33: high word 2, low word 0.
    do_op(MULHI, 32'h8000_0000, 32'd4, 5'd1, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'd2) begin
      miscompares++; $display("FAIL mulhi_carry: got %0h expected 2", d);
    end
    do_op(MULLO, 32'h8000_0000, 32'd4, 5'd1, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++; $display("FAIL mullo_carry: got %0h expected 0", d);
    end
  endtask

  task automatic test_div();
    int fw, nw, bh;
    logic [WORD-1:0] d;
    logic [4:0] ad;
    do_op(DIVU, 32'd100, 32'd7, 5'd6, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'd14) begin
      miscompares++; $display("FAIL divu_100_7: got %0d expected 14", d);
    end
    vectors++;
    if (fw !== int'(WORD) + 1) begin
      miscompares++; $display("FAIL divu_latency: got %0d expected %0d", fw, WORD + 1);
    end
    do_op(REMU, 32'd100, 32'd7, 5'd6, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'd2) begin
      miscompares++; $display("FAIL remu_100_7: got %0d expected 2", d);
    end
    do_op(DIVU, 32'd25, 32'd0, 5'd6, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++; $display("FAIL divu_by_zero: got %0h expected ffffffff", d);
    end
    vectors++;
    if (fw !== int'(WORD) + 1) begin
      miscompares++; $display("FAIL divu_zero_latency: got %0d expected %0d", fw, WORD + 1);
    end
    do_op(REMU, 32'd25, 32'd0, 5'd6, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'd25) begin
      miscompares++; $display("FAIL remu_by_zero: got %0d expected 25", d);
    end
    do_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd6, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'd1) begin
      miscompares++; $display("FAIL divu_msb_divisor: got %0h expected 1", d);
    end
    do_op(REMU, 32'hFFFF_FFFF, 32'h8000_0000, 5'd6, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'h7FFF_FFFF) begin
      miscompares++; $display("FAIL remu_msb_divisor: got %0h expected 7fffffff", d);
    end
    do_op(DIVU, 32'hFFFF_FFFF, 32'h10, 5'd6, fw, nw, d, ad, bh);
    vectors++;
    if (d !== 32'h0FFF_FFFF) begin
      miscompares++; $display("FAIL divu_by_16: got %0h expected fffffff", d);
    end
  endtask

  // 3*4 -> r2; starts during RUN and DONE are ignored; a start in the IDLE cycle right
  // after DONE is accepted (9*9 -> r3).
  task automatic test_back_to_back();
    int nw;
    int w_off[2];
    logic [WORD-1:0] w_data[2];
    logic [4:0] w_addr[2];
    logic busy_after_done;
    logic busy_restart;
    nw = 0;
    busy_after_done = 1'bx;
    busy_restart = 1'bx;
    op = MULLO; A = 32'd3; B = 32'd4; dest = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i <= 2 * int'(WORD) + 8; i++) begin
      if (i > 0) tick();
      if (write) begin
        if (nw < 2) begin
          w_off[nw] = i; w_data[nw] = write_data; w_addr[nw] = address_dest;
        end
        nw++;
      end
      if (i == int'(WORD) + 1) busy_after_done = busy;
      if (i == int'(WORD) + 2) busy_restart = busy;
      if (i == 4) begin
        op = MULLO; A = 32'd9; B = 32'd9; dest = 5'd7; start = 1'b1;
      end else if (i == 5) begin
        start = 1'b0;
      end else if (i == int'(WORD)) begin
        op = MULLO; A = 32'd100; B = 32'd100; dest = 5'd9; start = 1'b1;
      end else if (i == int'(WORD) + 1) begin
        A = 32'd9; B = 32'd9; dest = 5'd3;
      end else if (i == int'(WORD) + 2) begin
        start = 1'b0;
      end
    end
    vectors++;
    if (nw !== 2) begin
      miscompares++; $display("FAIL b2b_write_count: got %0d expected 2", nw);
    end
    if (nw >= 1) begin
      vectors++;
      if (w_off[0] !== int'(WORD) + 1 || w_data[0] !== 32'd12 || w_addr[0] !== 5'd2) begin
        miscompares++;
        $display("FAIL b2b_first: got off %0d data %0d r%0d expected off %0d data 12 r2",
                 w_off[0], w_data[0], w_addr[0], WORD + 1);
      end
    end
    if (nw >= 2) begin
      vectors++;
      if (w_off[1] !== 2 * int'(WORD) + 3 || w_data[1] !== 32'd81 || w_addr[1] !== 5'd3) begin
        miscompares++;
        $display("FAIL b2b_second: got off %0d data %0d r%0d expected off %0d data 81 r3",
                 w_off[1], w_data[1], w_addr[1], 2 * WORD + 3);
      end
    end
    vectors++;
    if (busy_after_done !== 1'b0) begin
      miscompares++; $display("FAIL b2b_idle_busy: got %b expected 0", busy_after_done);
    end
    vectors++;
    if (busy_restart !== 1'b1) begin
      miscompares++; $display("FAIL b2b_restart_busy: got %b expected 1", busy_restart);
    end
  endtask

  task automatic test_reset_abort();
    int nw;
    op = DIVU; A = 32'd1000; B = 32'd3; dest = 5'd4; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_busy: got %b expected 0", busy);
    end
    vectors++;
    if (write !== 1'b0) begin
      miscompares++; $display("FAIL abort_write: got %b expected 0", write);
    end
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (write) nw++;
    end
    vectors++;
    if (nw !== 0) begin
      miscompares++; $display("FAIL abort_no_write: got %0d writes expected 0", nw);
    end
    // Reset wins over a simultaneous start.
    op = MULLO; A = 32'd2; B = 32'd2; dest = 5'd8; start = 1'b1; reset = 1'b1;
    tick();
    start = 1'b0; reset = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_priority: got busy %b expected 0", busy);
    end
  endtask

  task automatic test_dest_zero();
    int fw, nw, bh;
    logic [WORD-1:0] d;
    logic [4:0] ad;
    do_op(MULLO, 32'd5, 32'd5, 5'd0, fw, nw, d, ad, bh);
    vectors++;
    if (nw !== 0) begin
      miscompares++; $display("FAIL dest0_write: got %0d writes expected 0", nw);
    end
    vectors++;
    if (bh !== int'(WORD) + 1) begin
      miscompares++; $display("FAIL dest0_busy_cycles: got %0d expected %0d", bh, WORD + 1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mullo();
    test_mul_wide();
    test_div();
    test_back_to_back();
    test_reset_abort();
    test_dest_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
